// File: rtl/div_phase_bridge.sv
// Full-rate companion to the toggle clock divider: tracks the divider phase, flags lost
// toggling, and carries half-rate words into the clk domain through a 2-entry buffer.
module div_phase_bridge #(
  parameter int WIDTH    = 32,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_q,
  input  logic             slow_valid,
  input  logic [WIDTH-1:0] slow_data,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             phase,
  output logic             rise,
  output logic             fall,
  output logic             locked,
  output logic             err,
  output logic             overflow
);

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [3:0] LC = 4'(LOCK_CNT);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_prev, r_rise, r_fall, r_err, w_err_nxt;
  logic             w_tog;

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr, r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_overflow;
  logic             w_push, w_pop, w_full, w_accept;

  assign w_tog = div_q ^ r_prev;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (!w_tog) begin
          w_cnt_nxt = 4'd0;
        end else if (r_cnt + 4'd1 == LC) begin
          w_state_nxt = ST_LOCKED;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_LOCKED: begin
        if (!w_tog) begin
          w_state_nxt = ST_UNLOCKED;
          w_cnt_nxt   = 4'd0;
          w_err_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_prev  <= div_q;
      r_rise  <= div_q & ~r_prev;
      r_fall  <= ~div_q & r_prev;
    end
  end

  // A push is taken only on a sampled divider rise while the phase tracker is locked.
  assign w_push   = (r_state == ST_LOCKED) & div_q & ~r_prev & slow_valid;
  assign w_pop    = m_valid & m_ready;
  assign w_full   = (r_count == 2'd2);
  assign w_accept = w_push & (~w_full | w_pop);

  // NOTE: the two storage words are reset so m_data is never X, even while m_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= slow_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push & w_full & ~w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_valid  = (r_count != 2'd0);
  assign m_data   = r_mem[r_rd_ptr];
  assign phase    = r_prev;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign locked   = (r_state == ST_LOCKED);
  assign err      = r_err;
  assign overflow = r_overflow;

endmodule
